// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and the
// 2-of-3 vote helper used by the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS   = 8;
  localparam int unsigned UART_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud.sv
// 16x oversampling baud generator. One tick every cfg_div+1 clocks; the
// sample strobes mark ticks 6, 8, 10 and 16 of the current bit period.
module uart_baud (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_div,
  input  logic        clear,
  output logic        baud_sample_6th,
  output logic        baud_sample_8th,
  output logic        baud_sample_10th,
  output logic        baud_sample_16th
);

  logic [15:0] div_cnt_q;
  logic [3:0]  sub_cnt_q;
  logic        tick;

  // >= keeps the prescaler bounded if cfg_div shrinks while counting
  assign tick = (div_cnt_q >= cfg_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else if (clear) begin
      div_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 16'd1;
      if (tick) sub_cnt_q <= sub_cnt_q + 4'd1;
    end
  end

  assign baud_sample_6th  = tick & (sub_cnt_q == 4'd5);
  assign baud_sample_8th  = tick & (sub_cnt_q == 4'd7);
  assign baud_sample_10th = tick & (sub_cnt_q == 4'd9);
  assign baud_sample_16th = tick & (sub_cnt_q == 4'd15);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised line, 2-of-3 majority sampling, optional second
// stop bit and a single-entry valid/ready output holding register.
module uart_rx
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               cfg_div,
  input  logic                      cfg_rxen,
  input  logic                      cfg_nstop,
  input  logic                      uart_rxd,
  output logic                      rx_valid,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_frame_err,
  input  logic                      rx_ready,
  output logic                      rx_overrun
);

  localparam int unsigned CntW = $clog2(UART_DATA_BITS);

  rx_state_e state_q, state_d;

  logic [UART_SYNC_STAGES-1:0] sync_q;
  logic                        rxd_s, rxd_prev_q;
  logic [2:0]                  votes_q;
  logic [UART_DATA_BITS-1:0]   shift_q;
  logic [CntW-1:0]             bit_cnt_q;
  logic                        stop_cnt_q;
  logic                        ferr_q;
  logic                        valid_q, ferr_out_q, overrun_q;
  logic [UART_DATA_BITS-1:0]   data_q;

  logic s6, s8, s10, s16;
  logic start_edge, bit_maj, stop_maj, last_bit, last_stop;
  logic baud_clear, shift_en, stop_eval, frame_done, load;

  uart_baud u_baud (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_div          (cfg_div),
    .clear            (baud_clear),
    .baud_sample_6th  (s6),
    .baud_sample_8th  (s8),
    .baud_sample_10th (s10),
    .baud_sample_16th (s16)
  );

  assign rxd_s      = sync_q[UART_SYNC_STAGES-1];
  assign start_edge = cfg_rxen & rxd_prev_q & ~rxd_s;
  assign bit_maj    = maj3(votes_q[0], votes_q[1], votes_q[2]);
  // Stop bits resolve at the 10th sample, so the live sample is the third vote
  assign stop_maj   = maj3(votes_q[0], votes_q[1], rxd_s);
  assign last_bit   = (bit_cnt_q == CntW'(UART_DATA_BITS - 1));
  assign last_stop  = ~cfg_nstop | stop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      StStart: if (s16) state_d = bit_maj ? StIdle : StData;
      StData:  if (s16 && last_bit) state_d = StStop;
      StStop:  if (s10 && last_stop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    baud_clear = (state_q == StIdle) & start_edge;
    shift_en   = (state_q == StData) & s16;
    stop_eval  = (state_q == StStop) & s10;
    frame_done = stop_eval & last_stop;
    load       = frame_done & (~valid_q | rx_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
      votes_q    <= '1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[UART_SYNC_STAGES-2:0], uart_rxd};
      rxd_prev_q <= rxd_s;
      if (s6)  votes_q[0] <= rxd_s;
      if (s8)  votes_q[1] <= rxd_s;
      if (s10) votes_q[2] <= rxd_s;
      if (baud_clear) begin
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        ferr_q     <= 1'b0;
      end
      if (shift_en) begin
        shift_q   <= {bit_maj, shift_q[UART_DATA_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (stop_eval) begin
        stop_cnt_q <= 1'b1;
        if (!stop_maj) ferr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= frame_done & valid_q & ~rx_ready;
      if (load) begin
        valid_q    <= 1'b1;
        data_q     <= shift_q;
        ferr_out_q <= ferr_q | ~stop_maj;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid     = valid_q;
  assign rx_data      = data_q;
  assign rx_frame_err = ferr_out_q;
  assign rx_overrun   = overrun_q;

endmodule
